camera_pixel_pio: RTL

CAMERA_PIXEL_PIO -- requirements
Module: camera_pixel_pio

---
 rtl/camera_pio_pkg.sv | 23 ++
 rtl/camera_pixel_pio_if.sv | 19 +
 rtl/camera_pio_fifo.sv | 58 +++++
 rtl/camera_pixel_pio.sv | 118 +++++++++++
 4 files changed

// File: rtl/camera_pio_pkg.sv
// rtl/camera_pio_pkg.sv - shared register map, status bit positions and edge mode encodings
package camera_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_STATUS   = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE     = 3'd3,
        ADDR_FIFO_POP = 3'd4
    } reg_addr_e;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int IRQ_OVF_EN = 31;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/camera_pixel_pio_if.sv
// rtl/camera_pixel_pio_if.sv - Avalon-MM register bus bundle
interface camera_pixel_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/camera_pio_fifo.sv
// rtl/camera_pio_fifo.sv - synchronous sample FIFO with occupancy count
module camera_pio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + ONE_CNT;
                2'b01:   cnt <= cnt - ONE_CNT;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/camera_pixel_pio.sv
// rtl/camera_pixel_pio.sv - pixel input port with sample FIFO, edge capture and interrupt
module camera_pixel_pio
    import camera_pio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int EDGE_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    camera_pixel_pio_if.slave     bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    input  logic                  in_valid,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] d_meta, d_s, d_q;
    logic                  v_meta, v_s;
    logic [DATA_WIDTH-1:0] edge_q, edge_hit;
    logic [DATA_WIDTH-1:0] mask_q;
    logic                  mask_ovf;
    logic                  ovf_q, ovf_set;
    logic                  wr_status, wr_mask, wr_edge, pop_req;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [31:0]           rd_next;
    logic                  unused_wdata;

    assign unused_wdata = ^bus.writedata;

    assign wr_status = bus.chipselect & bus.write & (bus.address == ADDR_STATUS);
    assign wr_mask   = bus.chipselect & bus.write & (bus.address == ADDR_IRQ_MASK);
    assign wr_edge   = bus.chipselect & bus.write & (bus.address == ADDR_EDGE);
    assign pop_req   = bus.chipselect & bus.read  & (bus.address == ADDR_FIFO_POP);

    // A full FIFO implies non-empty, so a concurrent pop request always makes room.
    assign ovf_set = v_s & fifo_full & ~pop_req;

    camera_pio_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (v_s),
        .pop   (pop_req),
        .din   (d_s),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Edge qualification against the one-cycle delayed copy of the synced data.
    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            EDGE_RISING:  edge_hit = d_s & ~d_q;
            EDGE_FALLING: edge_hit = ~d_s & d_q;
            EDGE_ANY:     edge_hit = d_s ^ d_q;
            default:      edge_hit = '0;
        endcase
    end

    // Address-selected read value; unused bits stay zero.
    always_comb begin
        rd_next = '0;
        case (reg_addr_e'(bus.address))
            ADDR_DATA:     rd_next[DATA_WIDTH-1:0] = d_s;
            ADDR_STATUS: begin
                rd_next[ST_EMPTY]             = fifo_empty;
                rd_next[ST_FULL]              = fifo_full;
                rd_next[ST_OVF]               = ovf_q;
                rd_next[ST_CNT_LSB +: CW]     = fifo_count;
            end
            ADDR_IRQ_MASK: begin
                rd_next[DATA_WIDTH-1:0] = mask_q;
                rd_next[IRQ_OVF_EN]     = mask_ovf;
            end
            ADDR_EDGE:     rd_next[DATA_WIDTH-1:0] = edge_q;
            ADDR_FIFO_POP: rd_next[DATA_WIDTH-1:0] = fifo_empty ? '0 : fifo_dout;
            default:       rd_next = '0;
        endcase
    end

    // Synchronizers, edge/overflow capture with set-wins-over-clear, mask, readdata and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_meta       <= '0;
            d_s          <= '0;
            d_q          <= '0;
            v_meta       <= 1'b0;
            v_s          <= 1'b0;
            edge_q       <= '0;
            mask_q       <= '0;
            mask_ovf     <= 1'b0;
            ovf_q        <= 1'b0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            d_meta <= in_port;
            d_s    <= d_meta;
            d_q    <= d_s;
            v_meta <= in_valid;
            v_s    <= v_meta;
            edge_q <= (edge_q & ~(wr_edge ? bus.writedata[DATA_WIDTH-1:0] : '0)) | edge_hit;
            ovf_q  <= (ovf_q & ~(wr_status & bus.writedata[ST_OVF])) | ovf_set;
            if (wr_mask) begin
                mask_q   <= bus.writedata[DATA_WIDTH-1:0];
                mask_ovf <= bus.writedata[IRQ_OVF_EN];
            end
            bus.readdata <= rd_next;
            irq          <= (|(edge_q & mask_q)) | (ovf_q & mask_ovf);
        end
    end
endmodule
